// File: rtl/afg_pkg.sv
// Shared definitions for the arbitrary function generator blocks.
// Holds the amplitude-constant bank sequencing states.
package afg_pkg;

    typedef enum logic [1:0] {
        AMC_IDLE  = 2'd0,
        AMC_ARMED = 2'd1,
        AMC_RAMP  = 2'd2
    } amc_state_e;

endpackage

// File: rtl/am_slew_ch.sv
// One amplitude channel: registered output that slews toward its target by
// a programmable step per enabled clock, never overshooting or wrapping.
module am_slew_ch #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STEP_W = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              en,
    input  logic [WIDTH-1:0]  target,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  dout,
    output logic              at_target
);

    // Wide enough for the unsigned distance and for any step value.
    localparam int unsigned XW = (STEP_W + 1 > WIDTH + 1) ? STEP_W + 1 : WIDTH + 1;

    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_d;
    logic [XW-1:0]    tgt_x;
    logic [XW-1:0]    out_x;
    logic [XW-1:0]    step_x;
    logic [XW-1:0]    mag;

    always_comb begin
        tgt_x  = XW'(target);
        out_x  = XW'(dout_q);
        step_x = XW'(step);
        if (tgt_x >= out_x) begin
            mag = tgt_x - out_x;
        end else begin
            mag = out_x - tgt_x;
        end

        dout_d = dout_q;
        if (en) begin
            if ((step == '0) || (mag <= step_x)) begin
                dout_d = target;
            end else if (tgt_x > out_x) begin
                dout_d = WIDTH'(out_x + step_x);
            end else begin
                dout_d = WIDTH'(out_x - step_x);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    // Looks at the next value so the ramp can finish on the same edge as the final step.
    assign at_target = (dout_d == target);
    assign dout      = dout_q;

endmodule

// File: rtl/am_const_bank.sv
// Double-buffered AM constant bank: host fills shadows, commit arms a transfer,
// the next period sync loads all targets at once and each channel then slews.
module am_const_bank
    import afg_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned STEP_W   = 8
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        wr_en,
    input  logic [$clog2(CHANNELS)-1:0] wr_addr,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic                        commit,
    input  logic                        sync,
    input  logic [STEP_W-1:0]           step,
    output logic [CHANNELS*WIDTH-1:0]   Dout,
    output logic                        busy,
    output logic                        pending
);

    logic [WIDTH-1:0]    shadow_q [CHANNELS];
    logic [WIDTH-1:0]    shadow_d [CHANNELS];
    logic [WIDTH-1:0]    target_q [CHANNELS];
    logic [WIDTH-1:0]    target_d [CHANNELS];
    logic [WIDTH-1:0]    ch_out   [CHANNELS];
    logic [CHANNELS-1:0] ch_at;
    amc_state_e          state_q;
    amc_state_e          state_d;
    logic                armed_q;
    logic                armed_d;
    logic                ramp_en;
    logic                all_at;

    always_comb begin
        shadow_d = shadow_q;
        if (wr_en && (32'(wr_addr) < CHANNELS)) begin
            shadow_d[wr_addr] = wr_data;
        end
    end

    assign ramp_en = (state_q == AMC_RAMP);
    assign all_at  = &ch_at;

    always_comb begin
        state_d  = state_q;
        armed_d  = armed_q;
        target_d = target_q;
        case (state_q)
            AMC_IDLE: begin
                if (commit) begin
                    state_d = AMC_ARMED;
                end
            end
            AMC_ARMED: begin
                // Targets take the registered shadows, so a same-cycle write is not seen.
                if (sync) begin
                    target_d = shadow_q;
                    state_d  = AMC_RAMP;
                end
            end
            AMC_RAMP: begin
                if (all_at) begin
                    armed_d = 1'b0;
                    state_d = (armed_q || commit) ? AMC_ARMED : AMC_IDLE;
                end else if (commit) begin
                    armed_d = 1'b1;
                end
            end
            default: begin
                state_d = AMC_IDLE;
                armed_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= AMC_IDLE;
            armed_q <= 1'b0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= '0;
                target_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            armed_q  <= armed_d;
            shadow_q <= shadow_d;
            target_q <= target_d;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        am_slew_ch #(
            .WIDTH  (WIDTH),
            .STEP_W (STEP_W)
        ) u_ch (
            .Clock     (Clock),
            .Reset     (Reset),
            .en        (ramp_en),
            .target    (target_q[k]),
            .step      (step),
            .dout      (ch_out[k]),
            .at_target (ch_at[k])
        );
        assign Dout[k*WIDTH +: WIDTH] = ch_out[k];
    end

    assign busy    = (state_q == AMC_RAMP);
    assign pending = (state_q == AMC_ARMED) || armed_q;

endmodule

// File: tb/tb_am_const_bank.sv
// Directed bench for am_const_bank: the driver queues hand-computed expected
// outputs per edge, a monitor pops and compares them just after each edge.
module tb_am_const_bank;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        commit = 1'b0;
    logic        sync = 1'b0;
    logic [7:0]  step = '0;
    logic [63:0] Dout;
    logic        busy;
    logic        pending;

    typedef struct {
        string       name;
        logic [63:0] dout;
        logic        busy;
        logic        pending;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          failed = 0;
    logic [15:0] ec [4];
    logic [7:0]  step_v;

    am_const_bank #(
        .WIDTH    (16),
        .CHANNELS (4),
        .STEP_W   (8)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .commit  (commit),
        .sync    (sync),
        .step    (step),
        .Dout    (Dout),
        .busy    (busy),
        .pending (pending)
    );

    always #5 Clock = ~Clock;

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic cyc(input logic rst, input logic we, input logic [1:0] a,
                       input logic [15:0] d, input logic cm, input logic sy,
                       input logic eb, input logic ep, input string nm);
        exp_t e;
        @(negedge Clock);
        Reset   = rst;
        wr_en   = we;
        wr_addr = a;
        wr_data = d;
        commit  = cm;
        sync    = sy;
        step    = step_v;
        e.name    = nm;
        e.dout    = {ec[3], ec[2], ec[1], ec[0]};
        e.busy    = eb;
        e.pending = ep;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge Clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                tests++;
                if (Dout !== e.dout || busy !== e.busy || pending !== e.pending) begin
                    failed++;
                    $display("FAIL %s: got Dout=%h busy=%b pending=%b, want Dout=%h busy=%b pending=%b",
                             e.name, Dout, busy, pending, e.dout, e.busy, e.pending);
                end
            end
        end
    end

    initial begin : driver
        step_v = 8'h00;
        for (int i = 0; i < 4; i++) ec[i] = 16'h0000;

        // Reset holds everything at zero regardless of other inputs.
        cyc(0, 0, 2'd0, 16'h0000, 0, 0, 0, 0, "reset");
        cyc(0, 1, 2'd0, 16'h1234, 1, 1, 0, 0, "rst_dom0");
        cyc(0, 1, 2'd1, 16'h5678, 1, 1, 0, 0, "rst_dom1");
        // Transfer of untouched shadows must leave Dout at zero.
        cyc(1, 0, 2'd0, 16'h0000, 1, 0, 0, 1, "commit_empty");
        cyc(1, 0, 2'd0, 16'h0000, 0, 1, 1, 0, "sync_empty");
        cyc(1, 0, 2'd0, 16'h0000, 0, 0, 0, 0, "ramp_zero");

        // Basic ramp, step 0x10.
        step_v = 8'h10;
        cyc(1, 1, 2'd0, 16'h0100, 0, 0, 0, 0, "wr_ch0");
        cyc(1, 1, 2'd1, 16'h0010, 0, 0, 0, 0, "wr_ch1");
        cyc(1, 0, 2'd0, 16'h0000, 1, 0, 0, 1, "commit_a");
        cyc(1, 0, 2'd0, 16'h0000, 1, 0, 0, 1, "commit_again");
        cyc(1, 0, 2'd0, 16'h0000, 0, 1, 1, 0, "sync_a");
        for (int i = 1; i <= 16; i++) begin
            ec[0] = 16'(16 * i);
            ec[1] = 16'h0010;
            cyc(1, 0, 2'd0, 16'h0000, 0, 0, (i < 16), 0, "ramp_a");
        end

        // Short downward move finishes in one step without undershoot.
        cyc(1, 1, 2'd0, 16'h00F8, 0, 0, 0, 0, "wr_ch0_f8");
        cyc(1, 0, 2'd0, 16'h0000, 1, 0, 0, 1, "commit_b");
        cyc(1, 0, 2'd0, 16'h0000, 0, 1, 1, 0, "sync_b");
        ec[0] = 16'h00F8;
        cyc(1, 0, 2'd0, 16'h0000, 0, 0, 0, 0, "no_undershoot");

        // step=0 jumps; commit+sync together in IDLE only arms.
        step_v = 8'h00;
        cyc(1, 1, 2'd2, 16'hFFFF, 0, 0, 0, 0, "wr_ch2");
        cyc(1, 0, 2'd0, 16'h0000, 1, 1, 0, 1, "commit_sync_idle");
        cyc(1, 0, 2'd0, 16'h0000, 0, 1, 1, 0, "sync_c");
        ec[2] = 16'hFFFF;
        cyc(1, 0, 2'd0, 16'h0000, 0, 0, 0, 0, "jump");

        // Commit during ramp re-arms; syncs during ramp are ignored.
        step_v = 8'h01;
        cyc(1, 1, 2'd3, 16'h0005, 0, 0, 0, 0, "wr_ch3");
        cyc(1, 0, 2'd0, 16'h0000, 1, 0, 0, 1, "commit_d");
        cyc(1, 0, 2'd0, 16'h0000, 0, 1, 1, 0, "sync_d");
        ec[3] = 16'h0001;
        cyc(1, 1, 2'd3, 16'h0002, 1, 0, 1, 1, "ramp_commit");
        ec[3] = 16'h0002;
        cyc(1, 0, 2'd0, 16'h0000, 0, 1, 1, 1, "ramp_sync_ign");
        ec[3] = 16'h0003;
        cyc(1, 0, 2'd0, 16'h0000, 0, 1, 1, 1, "ramp_sync_ign2");
        ec[3] = 16'h0004;
        cyc(1, 0, 2'd0, 16'h0000, 0, 0, 1, 1, "ramp_d4");
        ec[3] = 16'h0005;
        cyc(1, 0, 2'd0, 16'h0000, 0, 0, 0, 1, "rearm");
        // Same-cycle write and sync: target takes the old shadow value (2).
        cyc(1, 1, 2'd3, 16'h0009, 0, 1, 1, 0, "sync_wr_same");
        ec[3] = 16'h0004;
        cyc(1, 0, 2'd0, 16'h0000, 0, 0, 1, 0, "ramp_down4");
        ec[3] = 16'h0003;
        cyc(1, 0, 2'd0, 16'h0000, 0, 0, 1, 0, "ramp_down3");
        ec[3] = 16'h0002;
        cyc(1, 0, 2'd0, 16'h0000, 0, 0, 0, 0, "pre_write_tgt");
        step_v = 8'h00;
        cyc(1, 0, 2'd0, 16'h0000, 1, 0, 0, 1, "commit_e");
        cyc(1, 0, 2'd0, 16'h0000, 0, 1, 1, 0, "sync_e");
        ec[3] = 16'h0009;
        cyc(1, 0, 2'd0, 16'h0000, 0, 0, 0, 0, "shadow_kept");

        // Reset mid-ramp with an armed commit clears everything.
        step_v = 8'h01;
        cyc(1, 1, 2'd0, 16'h0000, 0, 0, 0, 0, "wr_ch0_zero");
        cyc(1, 0, 2'd0, 16'h0000, 1, 0, 0, 1, "commit_f");
        cyc(1, 0, 2'd0, 16'h0000, 0, 1, 1, 0, "sync_f");
        ec[0] = 16'h00F7;
        cyc(1, 0, 2'd0, 16'h0000, 1, 0, 1, 1, "ramp_f_commit");
        for (int i = 0; i < 4; i++) ec[i] = 16'h0000;
        cyc(0, 0, 2'd0, 16'h0000, 0, 0, 0, 0, "mid_reset");
        cyc(1, 0, 2'd0, 16'h0000, 0, 1, 0, 0, "post_reset_sync");
        cyc(1, 0, 2'd0, 16'h0000, 0, 0, 0, 0, "post_reset_idle");

        repeat (3) @(posedge Clock);
        #2;
        if (sb.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/am_const_bank.md
# am_const_bank

Multi-channel, double-buffered amplitude-modulation constant register bank for the arbitrary function generator. Host writes per-channel values into shadow registers. A commit arms a transfer; on the next waveform-period sync pulse every channel's target updates at once. Each output then slews to its target at a programmable step per clock, so the AM multiplier never sees an amplitude discontinuity mid-period.

## Interface
- WIDTH, 16, bit width of each channel's constant
- CHANNELS, 4, number of channels (≥2)
- STEP_W, 8, width of slew step input
- Clock  input  1  system clock, all logic on rising edge
- Reset  input  1  synchronous, active-low
- wr_en  input  1  write shadow register wr_addr with wr_data this cycle
- wr_addr  input  $clog2(CHANNELS)  shadow index; values ≥ CHANNELS ignored
- wr_data  input  WIDTH  shadow write data (unsigned)
- commit  input  1  arm a shadow→target transfer
- sync  input  1  waveform period boundary pulse
- step  input  STEP_W  slew increment per clock (unsigned); 0 = jump immediately
- Dout  output  CHANNELS*WIDTH  active values; channel k at bits [k*WIDTH +: WIDTH]
- busy  output  1  high while any channel is slewing
- pending  output  1  high while a commit is armed and not yet applied

## Operation
- Reset (Reset==0 at an edge): shadows, targets, Dout all 0; FSM IDLE; armed flag 0; busy=0, pending=0. Reset dominates all other inputs.
- Shadow write: on edge with wr_en=1 and wr_addr<CHANNELS, shadow[wr_addr] <= wr_data. Writes are accepted in every state.
- FSM states: IDLE, ARMED, RAMP.
  - IDLE: commit → ARMED. sync ignored.
  - ARMED: sync → load all targets from shadows, go RAMP. commit again: no effect.
  - RAMP: slew all channels. When every Dout channel equals its target at the end of a cycle → ARMED if armed flag set (clear flag), else IDLE. commit sets armed flag. sync ignored.
- Slew per channel each RAMP cycle, unsigned, computed in WIDTH+1 bits: d = target − out. If |d| ≤ step or step==0: out <= target. Else out <= out + step (d>0) or out − step (d<0). There is no overshoot and no wrap.
- step is sampled every cycle; changing it mid-ramp takes effect on the next cycle.
- Same-cycle wr_en and sync in ARMED: target receives the pre-write shadow value; the new value stays in the shadow.
- commit and sync in the same cycle in IDLE: only commit acts (→ARMED); the transfer waits for the next sync.
- pending = (state==ARMED) | armed flag. busy = (state==RAMP).

## Timing
- Edge E0 samples commit → pending=1 after E0.
- Edge E1 samples sync in ARMED → targets loaded, pending=0 (unless armed flag), busy=1 after E1.
- First Dout change on edge E1+1; ramp of distance D takes ceil(D/step) cycles (1 cycle if step=0).
- busy drops on the edge after the last channel reaches its target, i.e. the same edge as that final step.
- Dout is registered with no combinational path from inputs.
- Minimum commit-to-output latency is 3 edges (commit, sync, step).

## Structure
- Shared package afg_pkg: FSM state enum (AMC_IDLE, AMC_ARMED, AMC_RAMP).
- One sub-module: am_slew_ch (one channel). It takes target, step and enable, and outputs the registered value and at_target. It is instantiated CHANNELS times with a generate loop.
- The top level holds the shadow array, the target array, the FSM and the AND-reduction of at_target.

## Test plan
- Reset → all Dout 0, busy=0, pending=0; hold Reset=0 with wr_en/commit/sync active → outputs stay 0.
- Write ch0=0x0100, ch1=0x0010, step=0x10, commit, sync → ch0 rises 0x10/cycle, reaches 0x0100 after 16 cycles; ch1 reaches 0x0010 in 1 cycle; busy falls after cycle 16.
- Ch0 at 0x0100, write 0x00F8, step=0x10, commit, sync → ch0 reaches 0x00F8 in exactly 1 step (no undershoot).
- step=0, write ch2=0xFFFF, commit, sync → Dout ch2=0xFFFF one edge after sync; busy high for 1 cycle.
- During RAMP, write new shadows and commit → pending stays 1; sync pulses during the ramp are ignored; new targets load only on the first sync after ramp completion.
- Reset asserted mid-ramp → next edge all Dout 0, FSM IDLE, armed flag cleared; a following sync without a new commit causes no change.
